// File: rtl/neander_pkg.sv
// -----------------------------------------------------------------------------
// neander_pkg
// Shared definitions for the Neander fetch/decode path: default instruction
// word geometry and the opcode encoding the control FSM decodes against.
// -----------------------------------------------------------------------------
package neander_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPC_W = 4;
    localparam int DEF_DEPTH = 2;

    typedef enum logic [3:0] {
        OPC_NOP = 4'b0000,
        OPC_STA = 4'b0001,
        OPC_LDA = 4'b0010,
        OPC_ADD = 4'b0011,
        OPC_OR  = 4'b0100,
        OPC_AND = 4'b0101,
        OPC_NOT = 4'b0110,
        OPC_JMP = 4'b1000,
        OPC_JN  = 4'b1001,
        OPC_JZ  = 4'b1010,
        OPC_HLT = 4'b1111
    } opcode_e;

    // Jumps are the instructions whose taken path must flush the prefetch queue.
    function automatic logic is_jump(input opcode_e opc);
        return (opc == OPC_JMP) || (opc == OPC_JN) || (opc == OPC_JZ);
    endfunction

endpackage

// File: rtl/ri_queue.sv
// -----------------------------------------------------------------------------
// ri_queue
// DEPTH-entry instruction prefetch queue between the memory data path and the
// control FSM. Holds fetched words in order and presents the oldest one with
// its opcode field split out. Valid/ready on both sides, occupancy count, and
// a flush that drops all prefetched words (taken jump).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      discard all entries (beats push/pop, loses to rst)
//   in_valid   fetched word present on in_data
//   in_data    fetched instruction word
//   in_ready   queue can accept a word (not full)
//   out_valid  head entry present (not empty)
//   out_ready  control unit consumes the head this cycle
//   out_data   head word, 0 when empty
//   opcode     top OPC_W bits of out_data (0 = NOP when empty)
//   count      number of valid entries
// -----------------------------------------------------------------------------
module ri_queue
    import neander_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPC_W = DEF_OPC_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [OPC_W-1:0]           opcode,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshake qualifiers come from registered count only, so a pop in the
    // same cycle never opens in_ready combinationally.
    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;

        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            cnt_nxt    = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
            if (push) begin
                wr_ptr_nxt = wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                cnt_nxt = cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt_nxt = cnt - CNT_ONE;
            end
        end
    end

    // The array is deliberately not reset; the empty-forcing on out_data keeps
    // stale contents from ever reaching the decoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
            if (push && !flush) begin
                mem[wr_ptr] <= in_data;
            end
        end
    end

    always_comb begin
        in_ready  = !full;
        out_valid = !empty;
        count     = cnt;
        out_data  = '0;
        if (!empty) begin
            out_data = mem[rd_ptr];
        end
        opcode = out_data[WIDTH-1 -: OPC_W];
    end

endmodule
